// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request bundle: requester A (ALU result) and requester B (load data),
// each with a valid/ready handshake, destination register index and write data.
interface regfile_wb_arbiter_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5
);
    logic              a_valid;
    logic              a_ready;
    logic [ADDR_W-1:0] a_reg;
    logic [DATA_W-1:0] a_data;

    logic              b_valid;
    logic              b_ready;
    logic [ADDR_W-1:0] b_reg;
    logic [DATA_W-1:0] b_data;

    // Requester side drives the requests and observes ready.
    modport master (
        output a_valid, a_reg, a_data,
        output b_valid, b_reg, b_data,
        input  a_ready, b_ready
    );

    // Arbiter side consumes the requests and drives ready.
    modport slave (
        input  a_valid, a_reg, a_data,
        input  b_valid, b_reg, b_data,
        output a_ready, b_ready
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the single regfile write port between the ALU
// writeback path (A) and the load writeback path (B). Each side has a 1-entry
// holding register; writes targeting ZERO_REG are accepted and silently dropped.
module regfile_wb_arbiter #(
    parameter int DATA_W   = 64,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 31
) (
    input  logic              clk,
    input  logic              reset,
    regfile_wb_arbiter_if.slave wb,
    output logic              RegWrite,
    output logic [ADDR_W-1:0] WriteRegister,
    output logic [DATA_W-1:0] WriteData,
    output logic              grant_b
);

    typedef enum logic {
        PREF_A = 1'b0,
        PREF_B = 1'b1
    } ptr_t;

    ptr_t ptr_q;
    ptr_t ptr_d;

    logic              hold_a_valid;
    logic [ADDR_W-1:0] hold_a_reg;
    logic [DATA_W-1:0] hold_a_data;
    logic              hold_b_valid;
    logic [ADDR_W-1:0] hold_b_reg;
    logic [DATA_W-1:0] hold_b_data;

    logic sel_a;
    logic sel_b;
    logic accept_a;
    logic accept_b;

    // Ready depends only on registered hold state, never on incoming valid.
    assign wb.a_ready = !hold_a_valid;
    assign wb.b_ready = !hold_b_valid;

    assign accept_a = wb.a_valid && !hold_a_valid;
    assign accept_b = wb.b_valid && !hold_b_valid;

    // Round-robin pointer register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q <= PREF_A;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // Pointer moves away from whichever side won; unchanged when nothing issues.
    always_comb begin
        ptr_d = ptr_q;
        if (sel_a) begin
            ptr_d = PREF_B;
        end else if (sel_b) begin
            ptr_d = PREF_A;
        end
    end

    // Grant decision from held entries; the pointer only breaks ties.
    always_comb begin
        sel_a = 1'b0;
        sel_b = 1'b0;
        if (hold_a_valid && hold_b_valid) begin
            sel_a = (ptr_q == PREF_A);
            sel_b = (ptr_q == PREF_B);
        end else begin
            sel_a = hold_a_valid;
            sel_b = hold_b_valid;
        end
    end

    // Holding register A: load on accept (unless zero register), clear on grant.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_a_valid <= 1'b0;
            hold_a_reg   <= '0;
            hold_a_data  <= '0;
        end else if (accept_a) begin
            hold_a_valid <= (wb.a_reg != ADDR_W'(ZERO_REG));
            hold_a_reg   <= wb.a_reg;
            hold_a_data  <= wb.a_data;
        end else if (sel_a) begin
            hold_a_valid <= 1'b0;
        end
    end

    // Holding register B: load on accept (unless zero register), clear on grant.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_b_valid <= 1'b0;
            hold_b_reg   <= '0;
            hold_b_data  <= '0;
        end else if (accept_b) begin
            hold_b_valid <= (wb.b_reg != ADDR_W'(ZERO_REG));
            hold_b_reg   <= wb.b_reg;
            hold_b_data  <= wb.b_data;
        end else if (sel_b) begin
            hold_b_valid <= 1'b0;
        end
    end

    // Registered regfile write port; index/data/grant_b hold last values when idle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            RegWrite      <= 1'b0;
            WriteRegister <= '0;
            WriteData     <= '0;
            grant_b       <= 1'b0;
        end else if (sel_a) begin
            RegWrite      <= 1'b1;
            WriteRegister <= hold_a_reg;
            WriteData     <= hold_a_data;
            grant_b       <= 1'b0;
        end else if (sel_b) begin
            RegWrite      <= 1'b1;
            WriteRegister <= hold_b_reg;
            WriteData     <= hold_b_data;
            grant_b       <= 1'b1;
        end else begin
            RegWrite      <= 1'b0;
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios plus random
// traffic compared every cycle against a transaction-level model of the arbiter
// and a model regfile.
module tb_regfile_wb_arbiter;

    localparam int DATA_W = 64;
    localparam int ADDR_W = 5;
    localparam int ZREG   = 31;

    logic              clk = 1'b0;
    logic              reset;
    logic              RegWrite;
    logic [ADDR_W-1:0] WriteRegister;
    logic [DATA_W-1:0] WriteData;
    logic              grant_b;

    regfile_wb_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    regfile_wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(ZREG)) dut (
        .clk           (clk),
        .reset         (reset),
        .wb            (bus.slave),
        .RegWrite      (RegWrite),
        .WriteRegister (WriteRegister),
        .WriteData     (WriteData),
        .grant_b       (grant_b)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Model: pending entry per requester, who won last, regfile port outputs.
    logic              m_ha;
    logic [ADDR_W-1:0] m_ha_r;
    logic [DATA_W-1:0] m_ha_d;
    logic              m_hb;
    logic [ADDR_W-1:0] m_hb_r;
    logic [DATA_W-1:0] m_hb_d;
    logic              m_last_b;
    logic              m_we;
    logic [ADDR_W-1:0] m_wr;
    logic [DATA_W-1:0] m_wd;
    logic              m_gb;
    logic              m_acc_a;
    logic [DATA_W-1:0] rf     [32];
    logic [DATA_W-1:0] dut_rf [32];

    task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ha = 0; m_ha_r = '0; m_ha_d = '0;
        m_hb = 0; m_hb_r = '0; m_hb_d = '0;
        m_last_b = 1'b1;
        m_we = 0; m_wr = '0; m_wd = '0; m_gb = 0;
        m_acc_a = 0;
    endtask

    task automatic drive_idle();
        bus.a_valid = 0; bus.a_reg = '0; bus.a_data = '0;
        bus.b_valid = 0; bus.b_reg = '0; bus.b_data = '0;
    endtask

    // One clock: capture the write the regfile sees, advance the model, compare.
    task automatic step();
        logic ready_a, ready_b;
        int   winner;
        if (RegWrite === 1'b1) dut_rf[WriteRegister] = WriteData;
        @(posedge clk);
        if (m_we) rf[m_wr] = m_wd;
        ready_a = !m_ha;
        ready_b = !m_hb;
        winner = 0;
        if (m_ha && m_hb) winner = m_last_b ? 1 : 2;
        else if (m_ha)    winner = 1;
        else if (m_hb)    winner = 2;
        if (winner == 1) begin
            m_we = 1; m_wr = m_ha_r; m_wd = m_ha_d; m_gb = 0; m_ha = 0; m_last_b = 0;
        end else if (winner == 2) begin
            m_we = 1; m_wr = m_hb_r; m_wd = m_hb_d; m_gb = 1; m_hb = 0; m_last_b = 1;
        end else begin
            m_we = 0;
        end
        m_acc_a = bus.a_valid && ready_a;
        if (m_acc_a && bus.a_reg != ADDR_W'(ZREG)) begin
            m_ha = 1; m_ha_r = bus.a_reg; m_ha_d = bus.a_data;
        end
        if (bus.b_valid && ready_b && bus.b_reg != ADDR_W'(ZREG)) begin
            m_hb = 1; m_hb_r = bus.b_reg; m_hb_d = bus.b_data;
        end
        #1;
        chk("RegWrite", DATA_W'(RegWrite), DATA_W'(m_we));
        chk("WriteRegister", DATA_W'(WriteRegister), DATA_W'(m_wr));
        chk("WriteData", WriteData, m_wd);
        chk("grant_b", DATA_W'(grant_b), DATA_W'(m_gb));
        chk("a_ready", DATA_W'(bus.a_ready), DATA_W'(!m_ha));
        chk("b_ready", DATA_W'(bus.b_ready), DATA_W'(!m_hb));
    endtask

    task automatic do_reset();
        drive_idle();
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_RegWrite", DATA_W'(RegWrite), 0);
        chk("rst_WriteRegister", DATA_W'(WriteRegister), 0);
        chk("rst_WriteData", WriteData, 0);
        chk("rst_grant_b", DATA_W'(grant_b), 0);
        chk("rst_a_ready", DATA_W'(bus.a_ready), 1);
        chk("rst_b_ready", DATA_W'(bus.b_ready), 1);
        @(negedge clk);
        reset = 1'b1;
        model_reset();
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            rf[i] = '0;
            dut_rf[i] = '0;
        end
        model_reset();
        drive_idle();
        reset = 1'b1;
        #1;
        do_reset();

        // Single A write: issued one edge after accept, lasts one cycle.
        bus.a_valid = 1; bus.a_reg = 5; bus.a_data = 64'hA5;
        step();
        drive_idle();
        chk("t1_accept_ready", DATA_W'(bus.a_ready), 0);
        chk("t1_accept_we", DATA_W'(RegWrite), 0);
        step();
        chk("t1_we", DATA_W'(RegWrite), 1);
        chk("t1_wr", DATA_W'(WriteRegister), 5);
        chk("t1_wd", WriteData, 64'hA5);
        chk("t1_gb", DATA_W'(grant_b), 0);
        chk("t1_ready", DATA_W'(bus.a_ready), 1);
        step();
        chk("t1_we_drop", DATA_W'(RegWrite), 0);

        // Simultaneous pair after reset: A then B on consecutive cycles.
        do_reset();
        bus.a_valid = 1; bus.a_reg = 3; bus.a_data = 64'h33;
        bus.b_valid = 1; bus.b_reg = 4; bus.b_data = 64'h44;
        step();
        drive_idle();
        step();
        chk("t2_first_we", DATA_W'(RegWrite), 1);
        chk("t2_first_wr", DATA_W'(WriteRegister), 3);
        chk("t2_first_gb", DATA_W'(grant_b), 0);
        step();
        chk("t2_second_we", DATA_W'(RegWrite), 1);
        chk("t2_second_wr", DATA_W'(WriteRegister), 4);
        chk("t2_second_wd", WriteData, 64'h44);
        chk("t2_second_gb", DATA_W'(grant_b), 1);
        step();
        // A single A write leaves the pointer preferring B for the next pair.
        bus.a_valid = 1; bus.a_reg = 8; bus.a_data = 64'h88;
        step();
        drive_idle();
        step();
        step();
        bus.a_valid = 1; bus.a_reg = 9;  bus.a_data = 64'h99;
        bus.b_valid = 1; bus.b_reg = 10; bus.b_data = 64'hAA;
        step();
        drive_idle();
        step();
        chk("t2_rr_first_wr", DATA_W'(WriteRegister), 10);
        chk("t2_rr_first_gb", DATA_W'(grant_b), 1);
        step();
        chk("t2_rr_second_wr", DATA_W'(WriteRegister), 9);
        chk("t2_rr_second_gb", DATA_W'(grant_b), 0);
        step();

        // Zero-register write is consumed and never issued.
        bus.a_valid = 1; bus.a_reg = 5'(ZREG); bus.a_data = 64'hA0;
        step();
        drive_idle();
        chk("t3_ready", DATA_W'(bus.a_ready), 1);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t3_no_write", DATA_W'(RegWrite), 0);
        end
        chk("t3_x31", dut_rf[31], 0);

        // Same destination from both sides: B (issued second) wins.
        do_reset();
        bus.a_valid = 1; bus.a_reg = 7; bus.a_data = 64'h1;
        bus.b_valid = 1; bus.b_reg = 7; bus.b_data = 64'h2;
        step();
        drive_idle();
        for (int i = 0; i < 4; i++) step();
        chk("t4_x7", dut_rf[7], 64'h2);

        // A continuously valid: eight writes, one accept per two cycles.
        begin
            int idx = 0;
            int cyc = 0;
            while (idx < 8 && cyc < 40) begin
                bus.a_valid = 1; bus.a_reg = ADDR_W'(idx); bus.a_data = 64'h100 + 64'(idx);
                step();
                if (m_acc_a) idx++;
                cyc++;
            end
            drive_idle();
            chk("t5_all_accepted", DATA_W'(idx), 8);
            chk("t5_cycles", DATA_W'(cyc), 15);
            for (int i = 0; i < 4; i++) step();
            for (int i = 0; i < 8; i++) chk("t5_readback", dut_rf[i], 64'h100 + 64'(i));
        end

        // Reset while both held and a write is on the port: nothing lands.
        do_reset();
        bus.a_valid = 1; bus.a_reg = 20; bus.a_data = 64'hDEAD;
        bus.b_valid = 1; bus.b_reg = 21; bus.b_data = 64'hBEEF;
        step();
        drive_idle();
        step();
        chk("t6_we_before", DATA_W'(RegWrite), 1);
        reset = 1'b0;
        #1;
        chk("t6_we_async", DATA_W'(RegWrite), 0);
        chk("t6_a_ready", DATA_W'(bus.a_ready), 1);
        chk("t6_b_ready", DATA_W'(bus.b_ready), 1);
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        for (int i = 0; i < 3; i++) step();
        chk("t6_x20", dut_rf[20], 0);
        chk("t6_x21", dut_rf[21], 0);

        // Random traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            bus.a_valid = 1'($urandom_range(0, 1));
            bus.a_reg   = ADDR_W'($urandom_range(0, 31));
            bus.a_data  = {$urandom, $urandom};
            bus.b_valid = 1'($urandom_range(0, 1));
            bus.b_reg   = ADDR_W'($urandom_range(0, 31));
            bus.b_data  = {$urandom, $urandom};
            step();
        end
        drive_idle();
        for (int i = 0; i < 4; i++) step();
        for (int i = 0; i < 32; i++) chk("rand_regfile", dut_rf[i], rf[i]);
        chk("rand_x31", dut_rf[31], 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
